// File: rtl/tex_column_sequencer_if.sv
// Texture request/response channel between the column sequencer and the textures lookup.
// Request level and fields are held stable by the master until the pixel returns.
interface tex_column_sequencer_if;
  logic        tex_req_out;
  logic [15:0] tex_wallx_out;
  logic [7:0]  tex_lineheight_out;
  logic [9:0]  tex_drawstart_out;
  logic [7:0]  tex_vcount_out;
  logic [3:0]  tex_id_out;
  logic [7:0]  tex_pixel_in;
  logic        tex_valid_in;

  modport master (
    output tex_req_out, tex_wallx_out, tex_lineheight_out, tex_drawstart_out,
           tex_vcount_out, tex_id_out,
    input  tex_pixel_in, tex_valid_in
  );

  modport slave (
    input  tex_req_out, tex_wallx_out, tex_lineheight_out, tex_drawstart_out,
           tex_vcount_out, tex_id_out,
    output tex_pixel_in, tex_valid_in
  );
endinterface

// File: rtl/tex_column_sequencer.sv
// Walks one ray column top to bottom and emits one framebuffer write per row:
// ceiling above the wall, texture pixels inside it, floor below it.
module tex_column_sequencer #(
  parameter int unsigned SCREEN_WIDTH  = 320,
  parameter int unsigned SCREEN_HEIGHT = 180,
  parameter logic [7:0]  CEIL_COLOR    = 8'h11,
  parameter logic [7:0]  FLOOR_COLOR   = 8'h22,
  parameter logic [7:0]  ERR_COLOR     = 8'hE0,
  parameter int unsigned TIMEOUT       = 64
) (
  input  logic                          pixel_clk_in,
  input  logic                          rst_n_in,
  input  logic                          col_valid_in,
  output logic                          col_ready_out,
  input  logic [8:0]                    col_hcount_in,
  input  logic [7:0]                    col_lineheight_in,
  input  logic [15:0]                   col_wallx_in,
  input  logic [3:0]                    col_texture_in,
  tex_column_sequencer_if.master        tex,
  output logic                          fb_we_out,
  output logic [16:0]                   fb_addr_out,
  output logic [7:0]                    fb_data_out,
  output logic                          col_done_out,
  output logic                          timeout_err_out
);

  localparam int unsigned TcntW   = $clog2(TIMEOUT + 1);
  localparam logic [7:0]  LastRow = 8'(SCREEN_HEIGHT - 1);

  typedef enum logic [2:0] {StIdle, StRow, StReq, StWait, StGap, StDone} state_e;

  state_e             state_q, state_d;
  logic [8:0]         hcount_q, hcount_d;
  logic [7:0]         lineheight_q, lineheight_d;
  logic [15:0]        wallx_q, wallx_d;
  logic [3:0]         texid_q, texid_d;
  logic [9:0]         drawstart_q, drawstart_d;
  logic [10:0]        drawend_q, drawend_d;
  logic [7:0]         vcount_q, vcount_d;
  logic [TcntW-1:0]   tcnt_q, tcnt_d;
  logic               fb_we_q, fb_we_d;
  logic [16:0]        fb_addr_q, fb_addr_d;
  logic [7:0]         fb_data_q, fb_data_d;
  logic               col_done_q, col_done_d;
  logic               timeout_err_q, timeout_err_d;

  logic               advance;
  logic [9:0]         drawstart_new;
  logic signed [10:0] vcount_s, drawstart_s, drawend_s;
  logic [16:0]        addr_cur;
  logic               id_ok;

  // Negative drawstart (tall walls) must survive as two's complement for the signed compares.
  assign drawstart_new = 10'(SCREEN_HEIGHT / 2) - 10'(col_lineheight_in >> 1);
  assign vcount_s      = signed'({3'b000, vcount_q});
  assign drawstart_s   = signed'({drawstart_q[9], drawstart_q});
  assign drawend_s     = signed'(drawend_q);
  assign addr_cur      = 17'(vcount_q) * 17'(SCREEN_WIDTH) + 17'(hcount_q);
  assign id_ok         = (texid_q >= 4'd2) && (texid_q <= 4'd9);

  always_comb begin
    state_d       = state_q;
    hcount_d      = hcount_q;
    lineheight_d  = lineheight_q;
    wallx_d       = wallx_q;
    texid_d       = texid_q;
    drawstart_d   = drawstart_q;
    drawend_d     = drawend_q;
    vcount_d      = vcount_q;
    tcnt_d        = tcnt_q;
    fb_we_d       = 1'b0;
    fb_addr_d     = fb_addr_q;
    fb_data_d     = fb_data_q;
    col_done_d    = 1'b0;
    timeout_err_d = timeout_err_q;
    advance       = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (col_valid_in) begin
          hcount_d     = col_hcount_in;
          lineheight_d = col_lineheight_in;
          wallx_d      = col_wallx_in;
          texid_d      = col_texture_in;
          drawstart_d  = drawstart_new;
          drawend_d    = {drawstart_new[9], drawstart_new} + 11'(col_lineheight_in) - 11'd1;
          vcount_d     = 8'd0;
          state_d      = StRow;
        end
      end
      StRow: begin
        if (vcount_s < drawstart_s || vcount_s > drawend_s || !id_ok) begin
          fb_we_d   = 1'b1;
          fb_addr_d = addr_cur;
          if (vcount_s < drawstart_s)    fb_data_d = CEIL_COLOR;
          else if (vcount_s > drawend_s) fb_data_d = FLOOR_COLOR;
          else                           fb_data_d = ERR_COLOR;
          advance   = 1'b1;
        end else begin
          state_d = StReq;
        end
      end
      StReq: begin
        tcnt_d  = '0;
        state_d = StWait;
      end
      StWait: begin
        if (tex.tex_valid_in) begin
          fb_we_d   = 1'b1;
          fb_addr_d = addr_cur;
          fb_data_d = tex.tex_pixel_in;
          state_d   = StGap;
        end else if (tcnt_q == TcntW'(TIMEOUT - 1)) begin
          fb_we_d       = 1'b1;
          fb_addr_d     = addr_cur;
          fb_data_d     = ERR_COLOR;
          timeout_err_d = 1'b1;
          state_d       = StGap;
        end else begin
          tcnt_d = tcnt_q + 1'b1;
        end
      end
      StGap:  advance = 1'b1;
      StDone: begin
        col_done_d = 1'b1;
        state_d    = StIdle;
      end
      default: state_d = StIdle;
    endcase

    if (advance) begin
      if (vcount_q == LastRow) begin
        state_d = StDone;
      end else begin
        vcount_d = vcount_q + 8'd1;
        state_d  = StRow;
      end
    end
  end

  always_ff @(posedge pixel_clk_in) begin
    if (!rst_n_in) begin
      state_q       <= StIdle;
      hcount_q      <= '0;
      lineheight_q  <= '0;
      wallx_q       <= '0;
      texid_q       <= '0;
      drawstart_q   <= '0;
      drawend_q     <= '0;
      vcount_q      <= '0;
      tcnt_q        <= '0;
      fb_we_q       <= 1'b0;
      fb_addr_q     <= '0;
      fb_data_q     <= '0;
      col_done_q    <= 1'b0;
      timeout_err_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      hcount_q      <= hcount_d;
      lineheight_q  <= lineheight_d;
      wallx_q       <= wallx_d;
      texid_q       <= texid_d;
      drawstart_q   <= drawstart_d;
      drawend_q     <= drawend_d;
      vcount_q      <= vcount_d;
      tcnt_q        <= tcnt_d;
      fb_we_q       <= fb_we_d;
      fb_addr_q     <= fb_addr_d;
      fb_data_q     <= fb_data_d;
      col_done_q    <= col_done_d;
      timeout_err_q <= timeout_err_d;
    end
  end

  assign col_ready_out          = (state_q == StIdle);
  assign tex.tex_req_out        = (state_q == StReq) || (state_q == StWait);
  assign tex.tex_wallx_out      = wallx_q;
  assign tex.tex_lineheight_out = lineheight_q;
  assign tex.tex_drawstart_out  = drawstart_q;
  assign tex.tex_vcount_out     = vcount_q;
  assign tex.tex_id_out         = texid_q;
  assign fb_we_out              = fb_we_q;
  assign fb_addr_out            = fb_addr_q;
  assign fb_data_out            = fb_data_q;
  assign col_done_out           = col_done_q;
  assign timeout_err_out        = timeout_err_q;

endmodule

// File: tb/tb_tex_column_sequencer.sv
// Scoreboard bench: a row-level reference model queues expected writes and requests,
// while a monitor and a texture responder check what the sequencer actually does.
module tb_tex_column_sequencer;

  localparam logic [7:0] Ceil  = 8'h11;
  localparam logic [7:0] Floor = 8'h22;
  localparam logic [7:0] Err   = 8'hE0;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        col_valid;
  logic        col_ready;
  logic [8:0]  col_hcount;
  logic [7:0]  col_lh;
  logic [15:0] col_wallx;
  logic [3:0]  col_tex;
  logic        fb_we;
  logic [16:0] fb_addr;
  logic [7:0]  fb_data;
  logic        col_done;
  logic        timeout_err;

  always #5 clk = ~clk;

  tex_column_sequencer_if tex ();

  tex_column_sequencer dut (
    .pixel_clk_in     (clk),
    .rst_n_in         (rst_n),
    .col_valid_in     (col_valid),
    .col_ready_out    (col_ready),
    .col_hcount_in    (col_hcount),
    .col_lineheight_in(col_lh),
    .col_wallx_in     (col_wallx),
    .col_texture_in   (col_tex),
    .tex              (tex),
    .fb_we_out        (fb_we),
    .fb_addr_out      (fb_addr),
    .fb_data_out      (fb_data),
    .col_done_out     (col_done),
    .timeout_err_out  (timeout_err)
  );

  typedef struct {logic [16:0] addr; logic [7:0] data;} wr_t;

  int          checks = 0;
  int          errors = 0;
  wr_t         exp_wr[$];
  int          exp_req_rows[$];
  int          done_cnt = 0;
  int          exp_done = 0;
  int          last_row = -1;
  int          lat = 1;
  bit          never = 1'b0;
  bit          sticky_exp = 1'b0;
  logic [7:0]  cur_lh;
  logic [3:0]  cur_id;
  logic [15:0] cur_wallx;
  logic [9:0]  cur_ds;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] tex_fn(input int v, input int id, input logic [15:0] wx);
    return 8'((v * 3 + id * 17 + int'(wx[7:0])) & 255);
  endfunction

  // Reference model: row classification straight from the column geometry.
  task automatic plan_column(input int h, input int lh, input int id, input logic [15:0] wx);
    int ds, de;
    wr_t w;
    ds = 90 - lh / 2;
    de = ds + lh - 1;
    cur_lh    = 8'(lh);
    cur_id    = 4'(id);
    cur_wallx = wx;
    cur_ds    = 10'(ds);
    for (int v = 0; v < 180; v++) begin
      w.addr = 17'(v * 320 + h);
      if (v < ds)                w.data = Ceil;
      else if (v > de)           w.data = Floor;
      else if (id < 2 || id > 9) w.data = Err;
      else begin
        exp_req_rows.push_back(v);
        if (never) begin
          w.data     = Err;
          sticky_exp = 1'b1;
        end else begin
          w.data = tex_fn(v, id, wx);
        end
      end
      exp_wr.push_back(w);
    end
  endtask

  // Write/done monitor.
  initial begin
    wr_t e;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (fb_we) begin
          if (exp_wr.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL fb_write: unexpected write addr=%0d data=0x%0h", fb_addr, fb_data);
          end else begin
            e = exp_wr.pop_front();
            chk("fb_addr", fb_addr, e.addr);
            chk("fb_data", fb_data, e.data);
          end
          last_row = int'(fb_addr) / 320;
        end
        if (col_done) begin
          done_cnt++;
          chk("writes_left_at_done", exp_wr.size(), 0);
          chk("reqs_left_at_done", exp_req_rows.size(), 0);
          chk("timeout_err_at_done", timeout_err, sticky_exp);
        end
      end
    end
  end

  // Texture responder: checks request fields, answers after lat cycles, injects stray valids.
  initial begin
    bit         prev = 1'b0;
    bit         busy = 1'b0;
    int         cnt = 0;
    int         r;
    logic [45:0] snap = '0;
    logic [45:0] now;
    tex.tex_valid_in = 1'b0;
    tex.tex_pixel_in = 8'h00;
    forever begin
      @(negedge clk);
      tex.tex_valid_in = 1'b0;
      if (!rst_n) begin
        prev = 1'b0;
        busy = 1'b0;
      end else begin
        now = {tex.tex_vcount_out, tex.tex_drawstart_out, tex.tex_lineheight_out,
               tex.tex_wallx_out, tex.tex_id_out};
        if (tex.tex_req_out && !prev) begin
          if (exp_req_rows.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL tex_req: unexpected request vcount=%0d", tex.tex_vcount_out);
          end else begin
            r = exp_req_rows.pop_front();
            chk("req_vcount", tex.tex_vcount_out, r);
          end
          chk("req_drawstart", tex.tex_drawstart_out, cur_ds);
          chk("req_lineheight", tex.tex_lineheight_out, cur_lh);
          chk("req_wallx", tex.tex_wallx_out, cur_wallx);
          chk("req_id", tex.tex_id_out, cur_id);
          snap = now;
          busy = 1'b1;
          cnt  = 0;
        end else if (tex.tex_req_out) begin
          chk("req_fields_stable", now, snap);
          if (busy) begin
            cnt++;
            if (!never && cnt == lat) begin
              tex.tex_valid_in = 1'b1;
              tex.tex_pixel_in = tex_fn(int'(tex.tex_vcount_out), int'(tex.tex_id_out),
                                        tex.tex_wallx_out);
              busy = 1'b0;
            end
          end
        end else if ($urandom_range(0, 3) == 0) begin
          tex.tex_valid_in = 1'b1;
          tex.tex_pixel_in = 8'($urandom);
        end
        prev = tex.tex_req_out;
      end
    end
  end

  task automatic send_column(input int h, input int lh, input int id, input logic [15:0] wx);
    int n = 0;
    @(negedge clk);
    while (!col_ready && n < 5000) begin
      @(negedge clk);
      n++;
    end
    if (!col_ready) begin
      checks++;
      errors++;
      $display("FAIL col_ready_wait: got 0 expected 1 after %0d cycles", n);
    end
    col_valid  = 1'b1;
    col_hcount = 9'(h);
    col_lh     = 8'(lh);
    col_tex    = 4'(id);
    col_wallx  = wx;
    @(negedge clk);
    col_valid = 1'b0;
    chk("ready_falls_after_accept", col_ready, 0);
  endtask

  task automatic run_column(input int h, input int lh, input int id, input int latency,
                            input bit nev);
    int target;
    int n = 0;
    logic [15:0] wx;
    wx     = 16'($urandom);
    lat    = latency;
    never  = nev;
    plan_column(h, lh, id, wx);
    exp_done++;
    target = done_cnt + 1;
    send_column(h, lh, id, wx);
    while (done_cnt < target && n < 30000) begin
      @(negedge clk);
      #1;
      n++;
    end
    chk("col_done_seen", done_cnt >= target, 1);
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, "_ready"}, col_ready, 1);
    chk({tag, "_req"}, tex.tex_req_out, 0);
    chk({tag, "_we"}, fb_we, 0);
    chk({tag, "_addr"}, fb_addr, 0);
    chk({tag, "_data"}, fb_data, 0);
    chk({tag, "_done"}, col_done, 0);
    chk({tag, "_timeout_err"}, timeout_err, 0);
    chk({tag, "_fields"}, {tex.tex_vcount_out, tex.tex_drawstart_out, tex.tex_lineheight_out,
                           tex.tex_wallx_out, tex.tex_id_out}, 0);
  endtask

  initial begin
    int n;
    rst_n      = 1'b0;
    col_valid  = 1'b0;
    col_hcount = '0;
    col_lh     = '0;
    col_tex    = '0;
    col_wallx  = '0;
    repeat (3) @(negedge clk);
    check_reset_values("reset");
    rst_n = 1'b1;

    run_column(5, 0, 3, 1, 1'b0);
    run_column(17, 20, 3, 18, 1'b0);
    run_column(319, 255, 4, int'($urandom_range(1, 8)), 1'b0);
    run_column(100, 10, 12, 1, 1'b0);
    run_column(200, 4, 2, 1, 1'b1);
    for (int i = 0; i < 4; i++)
      run_column(int'($urandom_range(0, 319)), int'($urandom_range(0, 255)),
                 int'($urandom_range(0, 15)), int'($urandom_range(1, 6)), 1'b0);

    // Abort a textured column at row 40; it must not complete.
    lat      = 3;
    never    = 1'b0;
    last_row = -1;
    plan_column(77, 255, 5, 16'h1234);
    send_column(77, 255, 5, 16'h1234);
    n = 0;
    while (last_row != 40 && n < 5000) begin
      @(negedge clk);
      #1;
      n++;
    end
    chk("abort_row_reached", last_row, 40);
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check_reset_values("abort");
    exp_wr.delete();
    exp_req_rows.delete();
    sticky_exp = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    run_column(42, 60, 9, 2, 1'b0);
    for (int i = 0; i < 3; i++)
      run_column(int'($urandom_range(0, 319)), int'($urandom_range(0, 255)),
                 int'($urandom_range(0, 15)), int'($urandom_range(1, 6)), 1'b0);

    repeat (5) @(negedge clk);
    chk("done_pulse_count", done_cnt, exp_done);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
